// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control FSM:
// state enum, opcode constants, mux/ALU encodings and the per-state output decode.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_WB_MEM    = 4'd6,
      S_EXEC_R    = 4'd7,
      S_EXEC_I    = 4'd8,
      S_WB_ALU    = 4'd9,
      S_BRANCH    = 4'd10,
      S_TRAP      = 4'd11
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   typedef enum logic [2:0] {
      CLS_NONE   = 3'd0,
      CLS_R      = 3'd1,
      CLS_I      = 3'd2,
      CLS_LOAD   = 3'd3,
      CLS_STORE  = 3'd4,
      CLS_BRANCH = 3'd5
   } inst_class_t;

   // fetch marks the FETCH state; ir_write/pc_write are derived from it and mem_ready.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       fetch;
      logic       pc_write_cond;
      logic       pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       illegal;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.fetch     = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.iord    = 1'b1;
         end
         S_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_WB_ALU: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_RS2;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_src        = 1'b1;
         end
         S_TRAP:  c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_opcode_classifier.sv
// Combinational opcode decoder: maps instr[6:0] to an instruction class and a legal flag.
module multicycle_control_fsm_opcode_classifier
   import multicycle_control_fsm_pkg::*;
(
   input  logic [6:0]  opcode,
   output inst_class_t cls,
   output logic        legal
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      cls   = CLS_NONE;
      legal = 1'b1;
      case (opcode)
         OP_R:      cls = CLS_R;
         OP_I:      cls = CLS_I;
         OP_LOAD:   cls = CLS_LOAD;
         OP_STORE:  cls = CLS_STORE;
         OP_BRANCH: cls = CLS_BRANCH;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle datapath: sequences fetch/decode/execute/memory/
// write-back, drives datapath controls from a registered state decode, counts retirements.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [6:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [31:0] retired
);

   state_t      state_q;
   state_t      state_next;
   ctrl_t       ctrl_q;
   logic [31:0] retired_q;
   logic        retire;
   inst_class_t cls;
   logic        legal;

   // alu_zero qualifies pc_write_cond inside the datapath; the FSM never branches on it.
   logic unused_alu_zero;
   assign unused_alu_zero = alu_zero;

   multicycle_control_fsm_opcode_classifier u_opcode_classifier (
      .opcode (opcode),
      .cls    (cls),
      .legal  (legal)
   );

   always_comb begin
      state_next = state_q;
      retire     = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_next = S_FETCH;
         S_FETCH: if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            if (!legal) begin
               state_next = S_TRAP;
            end else begin
               case (cls)
                  CLS_R:               state_next = S_EXEC_R;
                  CLS_I:               state_next = S_EXEC_I;
                  CLS_LOAD, CLS_STORE: state_next = S_MEM_ADDR;
                  CLS_BRANCH:          state_next = S_BRANCH;
                  default:             state_next = S_TRAP;
               endcase
            end
         end
         // The opcode is re-examined here; anything but load/store is treated as illegal.
         S_MEM_ADDR: begin
            if (cls == CLS_LOAD)       state_next = S_MEM_READ;
            else if (cls == CLS_STORE) state_next = S_MEM_WRITE;
            else                       state_next = S_TRAP;
         end
         S_MEM_READ: if (mem_ready) state_next = S_WB_MEM;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
         S_WB_MEM, S_WB_ALU, S_BRANCH: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs are loaded from the decode of the next state, so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         retired_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
         state_q <= state_next;
         ctrl_q  <= state_ctrl(state_next);
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   assign mem_req       = ctrl_q.mem_req;
   assign mem_we        = ctrl_q.mem_we;
   assign iord          = ctrl_q.iord;
   assign ir_write      = ctrl_q.fetch & mem_ready;
   assign pc_write      = ctrl_q.fetch & mem_ready;
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign pc_src        = ctrl_q.pc_src;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign reg_write     = ctrl_q.reg_write;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign illegal       = ctrl_q.illegal;
   assign retired       = retired_q;

endmodule
